// File: rtl/inv_shift_rows_stream_if.sv
// Byte-in / state-out handshake bundle for the inverse ShiftRows stream stage.
// slave: the permutation block (consumes bytes, produces 128-bit states).
// master: the surrounding logic (produces bytes, consumes states).
interface inv_shift_rows_stream_if;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows stage. Each incoming byte is written straight
// into its InvShiftRows destination, so a completed block is already permuted.
// Optional macro INV_SHIFT_ROWS_PINGPONG_EN: two banks so collection of the next
// block overlaps with holding the previous one on the output.
module inv_shift_rows_stream #(
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    inv_shift_rows_stream_if.slave  bus,
    input  logic                    abort,
    output logic [CNT_W-1:0]        blk_cnt,
    output logic                    busy
);
    logic [3:0]       k_reg;
    logic [CNT_W-1:0] blk_cnt_reg;
    logic             wr_en;
    logic             out_acc;
    logic [3:0]       src_idx;
    logic [3:0]       dst_idx;
    logic [15:0]      byte_we;

    // Stream position -> state index -> (r, c) -> destination r + 4*((c+r) mod 4).
    assign src_idx = (MSB_FIRST != 0) ? ~k_reg : k_reg;
    assign dst_idx = {src_idx[3:2] + src_idx[1:0], src_idx[1:0]};

    for (genvar gi = 0; gi < 16; gi++) begin : g_we
        assign byte_we[gi] = wr_en && (dst_idx == 4'(gi));
    end

`ifdef INV_SHIFT_ROWS_PINGPONG_EN
    logic [127:0] bank_reg [2];
    logic [1:0]   full_reg;
    logic         wr_sel_reg;
    logic         rd_sel_reg;
    logic         last_byte;

    assign bus.s_ready = rst_n && !full_reg[wr_sel_reg];
    assign bus.m_valid = full_reg[rd_sel_reg];
    assign bus.m_data  = bank_reg[rd_sel_reg];
    assign wr_en       = bus.s_valid && bus.s_ready && !abort;
    assign out_acc     = bus.m_valid && bus.m_ready && !abort;
    assign last_byte   = wr_en && (k_reg == 4'hF);

    // Bank occupancy and pointers; the write and read banks differ whenever
    // both a fill and a drain complete in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            full_reg   <= 2'b00;
            wr_sel_reg <= 1'b0;
            rd_sel_reg <= 1'b0;
        end else begin
            if (last_byte) begin
                full_reg[wr_sel_reg] <= 1'b1;
                wr_sel_reg           <= ~wr_sel_reg;
            end
            if (out_acc) begin
                full_reg[rd_sel_reg] <= 1'b0;
                rd_sel_reg           <= ~rd_sel_reg;
            end
        end
    end

    // Byte writes into the bank currently being collected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_reg[0] <= '0;
            bank_reg[1] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (byte_we[i]) begin
                    bank_reg[wr_sel_reg][8*i +: 8] <= bus.s_data;
                end
            end
        end
    end
`else
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [127:0] data_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake qualification; abort suppresses both handshakes.
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        out_acc    = 1'b0;
        if (abort) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (bus.s_valid) begin
                        wr_en = 1'b1;
                        if (k_reg == 4'hF) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        out_acc    = 1'b1;
                        state_next = COLLECT;
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    // Ready is a decode of the registered state only (gated low while in reset).
    assign bus.s_ready = rst_n && (state_reg == COLLECT);
    assign bus.m_valid = (state_reg == HOLD);
    assign bus.m_data  = data_reg;

    // Byte writes directly into permuted positions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (byte_we[i]) begin
                    data_reg[8*i +: 8] <= bus.s_data;
                end
            end
        end
    end
`endif

    // Stream byte counter; wraps to 0 after the 16th byte.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            k_reg <= 4'd0;
        end else if (wr_en) begin
            k_reg <= k_reg + 4'd1;
        end
    end

    // Delivered-block counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_reg <= '0;
        end else if (out_acc) begin
            blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
        end
    end

    assign blk_cnt = blk_cnt_reg;
    assign busy    = (k_reg != 4'd0);
endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share one byte
// stream; expected states come from a plain InvShiftRows reference model.
module tb_inv_shift_rows_stream;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [127:0] exp;
        logic [127:0] src;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       m_ready = 1'b0;
    logic       rand_ready = 1'b0;

    logic [CNT_W-1:0] blk_cnt0, blk_cnt1;
    logic             busy0, busy1;
    logic [CNT_W-1:0] exp_cnt0 = '0;
    logic [CNT_W-1:0] exp_cnt1 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [7:0] stream_bytes [16];
    int nb = 0;

    always #5 clk = ~clk;

    inv_shift_rows_stream_if bus0 ();
    inv_shift_rows_stream_if bus1 ();

    assign bus0.s_valid = s_valid;
    assign bus0.s_data  = s_data;
    assign bus0.m_ready = m_ready;
    assign bus1.s_valid = s_valid;
    assign bus1.s_data  = s_data;
    assign bus1.m_ready = m_ready;

    inv_shift_rows_stream #(.MSB_FIRST(0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .abort(abort),
        .blk_cnt(blk_cnt0), .busy(busy0)
    );

    inv_shift_rows_stream #(.MSB_FIRST(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .abort(abort),
        .blk_cnt(blk_cnt1), .busy(busy1)
    );

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    // out(r,c) = in(r,(c-r) mod 4)
    function automatic logic [127:0] inv_shift(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = st[8*(r+4*((c-r+4)%4)) +: 8];
        return o;
    endfunction

    // out(r,c) = in(r,(c+r) mod 4)
    function automatic logic [127:0] fwd_shift(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = st[8*(r+4*((c+r)%4)) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] pack_state(input bit msb);
        logic [127:0] st;
        st = '0;
        for (int k = 0; k < 16; k++)
            st[8*(msb ? 15-k : k) +: 8] = stream_bytes[k];
        return st;
    endfunction

    function automatic void push_block();
        logic [127:0] st0, st1;
        st0 = pack_state(1'b0);
        st1 = pack_state(1'b1);
        q0.push_back({inv_shift(st0), st0});
        q1.push_back({inv_shift(st1), st1});
        $display("in  block state=%h", st0);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        waited = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!bus0.s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus0.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: actual 0 required 1");
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            stream_bytes[nb] = b;
            nb++;
            if (nb == 16) begin
                push_block();
                nb = 0;
            end
        end
    endtask

    task automatic send_block(input bit gaps);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), gaps);
        s_valid = 1'b0;
    endtask

    // Random downstream backpressure when enabled.
    always @(negedge clk) begin
        if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
    end

    // Monitor, LSB-first instance: sample mid-cycle, pop on each upcoming handshake.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_cnt0 = '0;
        end else if (!abort && bus0.m_valid && m_ready) begin
            check("blk_cnt0_at_accept", 128'(blk_cnt0), 128'(exp_cnt0));
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out0: actual %h required none", bus0.m_data);
            end else begin
                e0 = q0.pop_front();
                check("m_data0", bus0.m_data, e0.exp);
                check("fwd_roundtrip0", fwd_shift(bus0.m_data), e0.src);
            end
            $display("out inst0 m_data=%h blk_cnt=%0d", bus0.m_data, blk_cnt0);
            exp_cnt0 = exp_cnt0 + CNT_W'(1);
        end
    end

    // Monitor, MSB-first instance.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_cnt1 = '0;
        end else if (!abort && bus1.m_valid && m_ready) begin
            check("blk_cnt1_at_accept", 128'(blk_cnt1), 128'(exp_cnt1));
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out1: actual %h required none", bus1.m_data);
            end else begin
                e1 = q1.pop_front();
                check("m_data1", bus1.m_data, e1.exp);
                check("fwd_roundtrip1", fwd_shift(bus1.m_data), e1.src);
            end
            $display("out inst1 m_data=%h blk_cnt=%0d", bus1.m_data, blk_cnt1);
            exp_cnt1 = exp_cnt1 + CNT_W'(1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        int waited;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 128'(bus0.s_ready), 128'(0));
        check("rst_m_valid", 128'(bus0.m_valid), 128'(0));
        check("rst_m_data", bus0.m_data, 128'(0));
        check("rst_blk_cnt", 128'(blk_cnt0), 128'(0));
        check("rst_busy", 128'(busy0), 128'(0));
        rst_n = 1'b1;
        #1;
        check("s_ready_after_rst", 128'(bus0.s_ready), 128'(1));

        // Known vector, latency of one cycle after the 16th byte
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check("lat_m_valid", 128'(bus0.m_valid), 128'(1));
        check("known_vector", bus0.m_data, 128'h0306090C0F0205080B0E0104070A0D00);
        @(negedge clk);
        check("known_blk_cnt", 128'(blk_cnt0), 128'(1));
        check("known_m_valid_drop", 128'(bus0.m_valid), 128'(0));

        // Backpressure: output held stable for 10 cycles
        m_ready = 1'b0;
        send_block(1'b0);
        @(negedge clk);
        held = bus0.m_data;
        check("hold_m_valid_first", 128'(bus0.m_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_m_valid", 128'(bus0.m_valid), 128'(1));
            check("hold_m_data", bus0.m_data, held);
`ifndef INV_SHIFT_ROWS_PINGPONG_EN
            check("hold_s_ready", 128'(bus0.s_ready), 128'(0));
`endif
            check("hold_blk_cnt", 128'(blk_cnt0), 128'(1));
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("hold_blk_cnt_after", 128'(blk_cnt0), 128'(2));

        // Abort after 7 bytes, then a full block
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        check("busy_partial", 128'(busy0), 128'(1));
        abort = 1'b1;
        nb = 0;
        @(negedge clk);
        abort = 1'b0;
        check("busy_after_abort", 128'(busy0), 128'(0));
        send_block(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort_blk_cnt", 128'(blk_cnt0), 128'(3));

        // Abort colliding with input and output handshakes
        m_ready = 1'b0;
        send_block(1'b0);
        @(negedge clk);
        abort   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        q0.delete();
        q1.delete();
        nb = 0;
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        check("collide_m_valid", 128'(bus0.m_valid), 128'(0));
        check("collide_blk_cnt", 128'(blk_cnt0), 128'(3));
        check("collide_busy", 128'(busy0), 128'(0));

        // Reset while holding a block
        m_ready = 1'b0;
        send_block(1'b0);
        @(negedge clk);
        check("pre_rst_m_valid", 128'(bus0.m_valid), 128'(1));
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        nb = 0;
        @(negedge clk);
        check("hold_rst_m_valid", 128'(bus0.m_valid), 128'(0));
        check("hold_rst_m_data", bus0.m_data, 128'(0));
        check("hold_rst_blk_cnt", 128'(blk_cnt0), 128'(0));
        rst_n   = 1'b1;
        m_ready = 1'b1;
        send_block(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_blk_cnt", 128'(blk_cnt0), 128'(1));

        // Random traffic with gaps and backpressure; 21 blocks wraps a 4-bit counter
        rand_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_block(1'b1);
        end
        rand_ready = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_q0_empty", 128'(q0.size()), 128'(0));
        check("drain_q1_empty", 128'(q1.size()), 128'(0));
        @(negedge clk);
        @(negedge clk);
        check("wrap_blk_cnt0", 128'(blk_cnt0), 128'(5));
        check("wrap_blk_cnt1", 128'(blk_cnt1), 128'(5));
        check("final_busy", 128'(busy0), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
Decryption-side counterpart of the 128-bit forward ShiftRows stage in the AES datapath. Accepts an AES state as a byte-serial stream with a valid/ready handshake and places each byte directly at its InvShiftRows destination. Presents the full permuted 128-bit state on a valid/ready output to the next inverse-cipher stage (InvSubBytes). Also provides a completed-block counter and a synchronous abort.

Parameters:
MSB_FIRST, 0, 0: first streamed byte is state byte 0 (bits [7:0]); 1: first byte is state byte 15 (bits [127:120])
CNT_W, 16, width of completed-block counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
s_valid  input  1  input byte valid
s_ready  output  1  block can accept a byte
s_data  input  8  input state byte
abort  input  1  synchronous discard of partial or held block
m_valid  output  1  permuted state valid
m_ready  input  1  downstream accepts state
m_data  output  128  InvShiftRows(state)
blk_cnt  output  CNT_W  blocks delivered, modulo 2^CNT_W
busy  output  1  partial block collected (byte count nonzero)

Behaviour:
- State layout: byte i = bits [8i+7:8i], row r = i mod 4, column c = i div 4.
- InvShiftRows: out(r,c) = in(r,(c-r) mod 4). Incoming byte (r,c) is written to index r + 4*((c+r) mod 4). No separate permutation stage.
- Stream index k = 0..15 from a 4-bit counter. State index = k (MSB_FIRST=0) or 15-k (MSB_FIRST=1).
- FSM states:
  - COLLECT: s_ready=1, m_valid=0. Each s_valid&s_ready advances k. The handshake at k=15 writes the last byte, clears k to 0 and moves to HOLD.
  - HOLD: s_ready=0, m_valid=1, m_data stable. On m_valid&m_ready: blk_cnt increments and the FSM returns to COLLECT.
- Latency: m_valid asserts the cycle after the 16th input handshake. A continuously streaming source at full rate gets 16 input cycles plus at least 1 output cycle per block.
- m_valid, once high, stays high with m_data unchanged until accepted. No combinational path from m_ready to s_ready in the base build; s_ready is registered-state decode only.
- blk_cnt wraps from all-ones to 0.
- busy = (k != 0).
- abort, highest priority below reset:
  - Clears k, drops m_valid, returns to COLLECT.
  - A same-cycle input or output handshake is ignored: no data written, blk_cnt unchanged.
- Reset (rst_n=0 at clk edge), including mid-block or mid-HOLD:
  - k=0, state COLLECT, m_valid=0, m_data=0, blk_cnt=0, s_ready=0 during the reset cycle, busy=0.
  - s_ready=1 from the first cycle after rst_n=1.
- s_data is ignored when s_valid=0. Bytes not yet written in a partial block retain their old values; this is not observable because m_valid=0.

Optional Feature:
INV_SHIFT_ROWS_PINGPONG_EN
- Defined:
  - Two 128-bit banks. Collection into the free bank continues while the other bank is held on m_data, so s_ready stays 1 in HOLD if a bank is free.
  - When both banks are full, s_ready=0.
  - Output order is strictly block order.
  - A simultaneous output accept and final-byte input handshake moves the new bank to the output on the next cycle without a bubble.
  - abort clears both banks' valid flags.
- Undefined: single bank, behaviour exactly as above.

Test Plan:
- Reset, then stream bytes 0x00..0x0F (MSB_FIRST=0) with m_ready=1 → m_valid 1 cycle after the last byte, m_data=128'h0306090C0F0205080B0E0104070A0D00, blk_cnt=1.
- Same stimulus with MSB_FIRST=1 (first byte to bits [127:120]) → m_data equals the expected InvShiftRows of the reversed state; the bench recomputes it with a reference model, and forward ShiftRows of m_data returns the input.
- Hold m_ready=0 for 10 cycles after a block → m_valid and m_data stable, s_ready=0 (base build), blk_cnt unchanged until acceptance.
- Abort after 7 bytes, then stream a full block → busy drops the cycle after abort, output reflects only the new block, blk_cnt=1.
- Assert rst_n=0 during HOLD → next cycle m_valid=0, m_data=0, blk_cnt=0; a subsequent block is delivered correctly.
- PINGPONG_EN build, back-to-back 3 blocks with m_ready=0 for 40 cycles → s_ready drops after the 2nd block. Blocks emerge in order once m_ready=1; blk_cnt=3. Set blk_cnt to 0xFFFF before the test and check the wrap to 0x0000.
